// File: rtl/sasa_cam.sv
// Score CAM downstream of the SASA controller: sequential load, 1-cycle parallel search
// returning a match vector, popcount and any-match flag.
module sasa_cam #(
  parameter int CAM_LEN = 16,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = $clog2(CAM_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               search_en,
  input  logic [DATA_W-1:0]  search_key,
  input  logic [1:0]         mode,
  output logic [CAM_LEN-1:0] match_vector,
  output logic               match_valid,
  output logic [CNT_W-1:0]   match_count,
  output logic               any_match,
  output logic [CNT_W-1:0]   entry_count,
  output logic               full,
  output logic               overflow
);

  // state   | meaning
  // EMPTY   | no valid entries
  // LOADING | 1..CAM_LEN-1 entries valid
  // READY   | all CAM_LEN entries valid, further writes overflow
  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  localparam int IDX_W = (CAM_LEN > 1) ? $clog2(CAM_LEN) : 1;

  state_t             state;
  logic [DATA_W-1:0]  entry [CAM_LEN];
  logic [CAM_LEN-1:0] valid;
  logic [CAM_LEN-1:0] hit;
  logic [CNT_W-1:0]   hit_count;
  logic [CNT_W-1:0]   wr_ptr;
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_ok;

  assign wr_idx      = wr_ptr[IDX_W-1:0];
  assign wr_ok       = wr_en && (state != READY);
  assign entry_count = wr_ptr;
  assign full        = (state == READY);

  // Compare against pre-write contents so a same-cycle write is never matched.
  always_comb begin
    hit       = '0;
    hit_count = '0;
    for (int i = 0; i < CAM_LEN; i++) begin
      case (mode)
        2'b00:   hit[i] = valid[i] && (entry[i] == search_key);
        2'b01:   hit[i] = valid[i] && (entry[i] >  search_key);
        2'b10:   hit[i] = valid[i] && (entry[i] >= search_key);
        default: hit[i] = 1'b0;
      endcase
      hit_count = hit_count + CNT_W'(hit[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !clear && wr_ok) begin
      entry[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= EMPTY;
      valid        <= '0;
      wr_ptr       <= '0;
      overflow     <= 1'b0;
      match_vector <= '0;
      match_valid  <= 1'b0;
      match_count  <= '0;
      any_match    <= 1'b0;
    end else if (clear) begin
      state       <= EMPTY;
      valid       <= '0;
      wr_ptr      <= '0;
      overflow    <= 1'b0;
      match_valid <= 1'b0;
    end else begin
      match_valid <= search_en;
      if (search_en) begin
        match_vector <= hit;
        match_count  <= hit_count;
        any_match    <= |hit;
      end
      if (wr_ok) begin
        valid[wr_idx] <= 1'b1;
        wr_ptr        <= wr_ptr + CNT_W'(1);
        state         <= (wr_ptr == CNT_W'(CAM_LEN - 1)) ? READY : LOADING;
      end else if (wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sasa_cam.sv
// Self-checking bench for sasa_cam: directed vector table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_sasa_cam;
  localparam int CAM_LEN = 16;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 5;

  logic               clk = 1'b0;
  logic               reset, clear, wr_en, search_en;
  logic [DATA_W-1:0]  wr_data, search_key;
  logic [1:0]         mode;
  logic [CAM_LEN-1:0] match_vector;
  logic               match_valid, any_match, full, overflow;
  logic [CNT_W-1:0]   match_count, entry_count;

  int checks = 0;
  int passed = 0;

  int unsigned    m_q[$];
  logic           m_ovf;
  logic [15:0]    m_vec;
  logic           m_val;

  typedef struct {
    logic [7:0]  key;
    logic [1:0]  md;
    logic [15:0] vec;
    int          cnt;
  } vec_t;
  vec_t tbl[10];

  sasa_cam #(.CAM_LEN(CAM_LEN), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .search_en(search_en), .search_key(search_key), .mode(mode),
    .match_vector(match_vector), .match_valid(match_valid), .match_count(match_count),
    .any_match(any_match), .entry_count(entry_count), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] model_search(input int unsigned key, input logic [1:0] md);
    logic [15:0] v = '0;
    for (int i = 0; i < m_q.size(); i++) begin
      if (md == 2'b00 && m_q[i] == key) v[i] = 1'b1;
      if (md == 2'b01 && m_q[i] >  key) v[i] = 1'b1;
      if (md == 2'b10 && m_q[i] >= key) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Advance one clock; the model applies the same inputs the DUT sees at that edge.
  task automatic step();
    if (!reset) begin
      m_q.delete(); m_ovf = 1'b0; m_vec = '0; m_val = 1'b0;
    end else if (clear) begin
      m_q.delete(); m_ovf = 1'b0; m_val = 1'b0;
    end else begin
      m_val = search_en;
      if (search_en) m_vec = model_search(search_key, mode);
      if (wr_en) begin
        if (m_q.size() < CAM_LEN) m_q.push_back(wr_data);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0;
    search_en = 1'b0; search_key = '0; mode = 2'b00;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 32'(match_valid), 32'(m_val));
    check({tag, "_vec"},   32'(match_vector), 32'(m_vec));
    check({tag, "_cnt"},   32'(match_count), 32'($countones(m_vec)));
    check({tag, "_any"},   32'(any_match), 32'(m_vec != 0));
    check({tag, "_ecnt"},  32'(entry_count), 32'(m_q.size()));
    check({tag, "_full"},  32'(full), 32'(m_q.size() == CAM_LEN));
    check({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"},   32'(match_vector), 32'h0);
    check({tag, "_valid"}, 32'(match_valid), 32'h0);
    check({tag, "_cnt"},   32'(match_count), 32'h0);
    check({tag, "_any"},   32'(any_match), 32'h0);
    check({tag, "_ecnt"},  32'(entry_count), 32'h0);
    check({tag, "_full"},  32'(full), 32'h0);
    check({tag, "_ovf"},   32'(overflow), 32'h0);
  endtask

  task automatic search_chk(input string tag, input logic [7:0] key, input logic [1:0] md,
                            input logic [15:0] vec, input int cnt);
    search_en = 1'b1; search_key = key; mode = md;
    step();
    search_en = 1'b0;
    check({tag, "_valid"}, 32'(match_valid), 32'h1);
    check({tag, "_vec"},   32'(match_vector), 32'(vec));
    check({tag, "_cnt"},   32'(match_count), 32'(cnt));
    check({tag, "_any"},   32'(any_match), 32'(cnt != 0));
  endtask

  initial begin
    tbl[0] = '{8'h05, 2'b00, 16'h0020, 1};
    tbl[1] = '{8'h0C, 2'b01, 16'hE000, 3};
    tbl[2] = '{8'h0C, 2'b10, 16'hF000, 4};
    tbl[3] = '{8'h0C, 2'b11, 16'h0000, 0};
    tbl[4] = '{8'h00, 2'b00, 16'h0001, 1};
    tbl[5] = '{8'h0F, 2'b01, 16'h0000, 0};
    tbl[6] = '{8'h00, 2'b10, 16'hFFFF, 16};
    tbl[7] = '{8'h0F, 2'b00, 16'h8000, 1};
    tbl[8] = '{8'hAA, 2'b00, 16'h0000, 0};
    tbl[9] = '{8'h07, 2'b01, 16'hFF00, 8};

    set_idle();
    m_q.delete(); m_ovf = 1'b0; m_vec = '0; m_val = 1'b0;
    reset = 1'b0;
    step(); step();
    check_all_zero("reset");
    reset = 1'b1;

    // Fill with 0x00..0x0F
    for (int i = 0; i < CAM_LEN; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == CAM_LEN - 2) check("full_at_15", 32'(full), 32'h0);
    end
    wr_en = 1'b0;
    check("load_ecnt", 32'(entry_count), 32'd16);
    check("load_full", 32'(full), 32'h1);
    check("load_ovf",  32'(overflow), 32'h0);

    wr_en = 1'b1; wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    check("ovf_set",  32'(overflow), 32'h1);
    check("ovf_ecnt", 32'(entry_count), 32'd16);

    // Back-to-back searches from the table
    for (int i = 0; i < 10; i++) begin
      search_chk($sformatf("tbl%0d", i), tbl[i].key, tbl[i].md, tbl[i].vec, tbl[i].cnt);
    end
    step();
    check("idle_valid", 32'(match_valid), 32'h0);
    check("idle_hold",  32'(match_vector), 32'hFF00);
    check("idle_cnt",   32'(match_count), 32'd8);
    check("ovf_hold",   32'(overflow), 32'h1);

    // Clear together with write and search
    clear = 1'b1; wr_en = 1'b1; wr_data = 8'h55; search_en = 1'b1; search_key = 8'h00; mode = 2'b10;
    step();
    set_idle();
    check("clr_ecnt",  32'(entry_count), 32'h0);
    check("clr_full",  32'(full), 32'h0);
    check("clr_ovf",   32'(overflow), 32'h0);
    check("clr_valid", 32'(match_valid), 32'h0);
    search_chk("clr_empty", 8'h55, 2'b00, 16'h0000, 0);

    // Partial load, invalid entries must never match
    wr_en = 1'b1; wr_data = 8'h80; step(); step();
    wr_data = 8'h10; step();
    wr_en = 1'b0;
    check("part_ecnt", 32'(entry_count), 32'd3);
    search_chk("part_eq",  8'h80, 2'b00, 16'h0003, 2);
    search_chk("part_ge0", 8'h00, 2'b10, 16'h0007, 3);

    // Write and search in the same cycle
    wr_en = 1'b1; wr_data = 8'h7F;
    search_chk("wrsrch_same", 8'h7F, 2'b00, 16'h0000, 0);
    wr_en = 1'b0;
    search_chk("wrsrch_next", 8'h7F, 2'b00, 16'h0008, 1);

    // Reset in the middle of a search
    search_en = 1'b1; search_key = 8'h80; mode = 2'b00; reset = 1'b0;
    step();
    set_idle();
    check_all_zero("rst_mid");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 99) != 0);
      clear      = ($urandom_range(0, 29) == 0);
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_data    = 8'($urandom_range(0, 7)) << $urandom_range(0, 5);
      search_en  = ($urandom_range(0, 1) == 1);
      search_key = 8'($urandom_range(0, 7)) << $urandom_range(0, 5);
      mode       = 2'($urandom_range(0, 3));
      step();
      check_model($sformatf("rnd%0d", n));
    end
    set_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
